// File: rtl/mp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mp_pkg : shared types and constants for the issue controller slice |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mp_pkg;

  localparam int OPC_W    = 6;
  localparam int REG_AW   = 5;
  localparam int INSTR_W  = 32;

  localparam int OPC_LSB  = 0;
  localparam int SRC1_LSB = 6;
  localparam int SRC2_LSB = 11;
  localparam int DST_LSB  = 16;
  localparam int FIELD_W  = DST_LSB + REG_AW;

  localparam logic [OPC_W-1:0] OPC_LAST = 6'd11;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] src1;
    logic [OPC_W-1:0]  opcode;
  } instr_t;

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return op <= OPC_LAST;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mp_instr_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mp_instr_fifo : DEPTH-entry instruction FIFO with synchronous flush |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mp_instr_fifo
  import mp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  instr_t                   din,
  output instr_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  instr_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/mp_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mp_issue_ctrl : instruction buffer, RAW stall and execute stage     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mp_issue_ctrl
  import mp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic                flush,
  output logic [REG_AW-1:0]   rd_addr1,
  output logic [REG_AW-1:0]   rd_addr2,
  output logic [OPC_W-1:0]    ex_opcode,
  output logic                wr_en,
  output logic [REG_AW-1:0]   wr_addr,
  output logic                stall,
  output logic                busy,
  output logic [CNT_W-1:0]    illegal_cnt,
  output logic [CNT_W-1:0]    stall_cnt
);

  instr_t                   w_head;
  logic                     w_full;
  logic                     w_empty;
  logic [$clog2(DEPTH):0]   w_count;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_can;
  logic                     w_hazard;
  logic                     w_issue;
  logic                     w_drop;
  logic                     w_stall;
  logic                     w_unused_bits;

  logic                     r_ex_valid;
  logic [OPC_W-1:0]         r_ex_opcode;
  logic [REG_AW-1:0]        r_ex_dst;
  logic [REG_AW-1:0]        r_rd1;
  logic [REG_AW-1:0]        r_rd2;
  logic [CNT_W-1:0]         r_illegal_cnt;
  logic [CNT_W-1:0]         r_stall_cnt;

  assign w_unused_bits = ^in_instr[INSTR_W-1:FIELD_W];

  // No pass-through at full: a same-cycle pop does not reopen the input.
  assign in_ready = rst_n && !w_full;
  assign w_push   = in_valid && in_ready && !flush;

  assign w_can    = !w_empty && !flush;
  assign w_hazard = r_ex_valid &&
                    ((r_ex_dst == w_head.src1) || (r_ex_dst == w_head.src2));
  assign w_drop   = w_can && !is_legal(w_head.opcode);
  assign w_stall  = w_can && is_legal(w_head.opcode) && w_hazard;
  assign w_issue  = w_can && is_legal(w_head.opcode) && !w_hazard;
  assign w_pop    = w_drop || w_issue;

  mp_instr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .din   (instr_t'(in_instr[FIELD_W-1:0])),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign rd_addr1    = w_issue ? w_head.src1 : r_rd1;
  assign rd_addr2    = w_issue ? w_head.src2 : r_rd2;
  assign ex_opcode   = r_ex_opcode;
  assign wr_en       = r_ex_valid;
  assign wr_addr     = r_ex_dst;
  assign stall       = w_stall;
  assign busy        = (w_count != '0) || r_ex_valid;
  assign illegal_cnt = r_illegal_cnt;
  assign stall_cnt   = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_opcode   <= '0;
      r_ex_dst      <= '0;
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_illegal_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_ex_valid <= w_issue;
      if (w_issue) begin
        r_ex_opcode <= w_head.opcode;
        r_ex_dst    <= w_head.dst;
        r_rd1       <= w_head.src1;
        r_rd2       <= w_head.src2;
      end
      if (w_drop && (r_illegal_cnt != '1))
        r_illegal_cnt <= r_illegal_cnt + 1'b1;
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mp_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mp_issue_ctrl : directed and random checks against a queue model |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mp_issue_ctrl;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic             flush = 1'b0;
  logic [4:0]       rd_addr1, rd_addr2, wr_addr;
  logic [5:0]       ex_opcode;
  logic             wr_en, stall, busy;
  logic [CNT_W-1:0] illegal_cnt, stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of pending words plus the execute-stage contents.
  logic [31:0] mq[$];
  bit          m_exv;
  logic [5:0]  m_exop;
  logic [4:0]  m_exdst, m_rd1, m_rd2;
  int          m_ill, m_stl;

  always #5 clk = ~clk;

  mp_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .ex_opcode(ex_opcode), .wr_en(wr_en), .wr_addr(wr_addr), .stall(stall),
    .busy(busy), .illegal_cnt(illegal_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_exv = 0; m_exop = '0; m_exdst = '0; m_rd1 = '0; m_rd2 = '0;
    m_ill = 0; m_stl = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, 32'(in_ready), 0);
    check({tag, ".wr_en"}, 32'(wr_en), 0);
    check({tag, ".wr_addr"}, 32'(wr_addr), 0);
    check({tag, ".ex_opcode"}, 32'(ex_opcode), 0);
    check({tag, ".stall"}, 32'(stall), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".illegal_cnt"}, 32'(illegal_cnt), 0);
    check({tag, ".stall_cnt"}, 32'(stall_cnt), 0);
    check({tag, ".rd_addr1"}, 32'(rd_addr1), 0);
    check({tag, ".rd_addr2"}, 32'(rd_addr2), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; in_instr = '0; flush = 0; rst_n = 0;
    #1;
    model_reset();
    check_all_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("post_reset.in_ready", 32'(in_ready), 1);
    check("post_reset.busy", 32'(busy), 0);
  endtask

  // One clock cycle: drive, compare every output with the model, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, output bit acc);
    bit h_ok, legal, haz, issue, drop, stl, e_ready;
    logic [31:0] hd;
    @(negedge clk);
    in_valid = v; in_instr = ins; flush = fl;
    #1;
    e_ready = (mq.size() < DEPTH);
    h_ok = (mq.size() != 0) && !fl;
    hd = h_ok ? mq[0] : 32'h0;
    legal = (hd[5:0] <= 6'd11);
    haz = m_exv && ((m_exdst == hd[10:6]) || (m_exdst == hd[15:11]));
    issue = h_ok && legal && !haz;
    drop = h_ok && !legal;
    stl = h_ok && legal && haz;
    if (issue) begin m_rd1 = hd[10:6]; m_rd2 = hd[15:11]; end
    check("in_ready", 32'(in_ready), 32'(e_ready));
    check("stall", 32'(stall), 32'(stl));
    check("rd_addr1", 32'(rd_addr1), 32'(m_rd1));
    check("rd_addr2", 32'(rd_addr2), 32'(m_rd2));
    check("wr_en", 32'(wr_en), 32'(m_exv));
    if (m_exv) check("wr_addr", 32'(wr_addr), 32'(m_exdst));
    check("ex_opcode", 32'(ex_opcode), 32'(m_exop));
    check("busy", 32'(busy), 32'((mq.size() != 0) || m_exv));
    check("illegal_cnt", 32'(illegal_cnt), 32'(m_ill));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stl));
    acc = v && e_ready && !fl;
    @(posedge clk);
    if (drop && m_ill < CMAX) m_ill++;
    if (stl && m_stl < CMAX) m_stl++;
    m_exv = issue;
    if (issue) begin m_exop = hd[5:0]; m_exdst = hd[20:16]; end
    if (fl) mq.delete();
    else begin
      if (issue || drop) void'(mq.pop_front());
      if (acc) mq.push_back(ins);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int s1, input int s2, input int d);
    return (32'(d) << 16) | (32'(s2) << 11) | (32'(s1) << 6) | 32'(op);
  endfunction

  initial begin
    bit a;
    int k, budget;

    // Reset then idle
    do_reset();
    repeat (2) step(0, 0, 0, a);

    // Independent pair
    do_reset();
    step(1, 32'h0004_1881, 0, a);
    step(1, 32'h000A_3140, 0, a);
    repeat (4) step(0, 0, 0, a);
    check("pair.stall_cnt", 32'(stall_cnt), 0);

    // RAW hazard
    do_reset();
    step(1, 32'h0004_1881, 0, a);
    step(1, 32'h0006_2902, 0, a);
    repeat (5) step(0, 0, 0, a);
    check("raw.stall_cnt", 32'(stall_cnt), 1);

    // Illegal drop between legal instructions
    do_reset();
    step(1, 32'h0004_1881, 0, a);
    step(1, 32'h0000_003F, 0, a);
    step(1, 32'h000A_3140, 0, a);
    repeat (5) step(0, 0, 0, a);
    check("illegal.illegal_cnt", 32'(illegal_cnt), 1);

    // Backpressure: dependent chain keeps the head stalling so the FIFO fills
    do_reset();
    k = 0; budget = 0;
    while (k < 6 && budget < 60) begin
      step(1, mk(1, k + 1, k + 1, k + 2), 0, a);
      if (a) k++;
      budget++;
    end
    check("full.accepted", 32'(k), 6);
    repeat (14) step(0, 0, 0, a);
    check("full.drained_busy", 32'(busy), 0);

    // Flush with instructions queued and one in execute
    do_reset();
    repeat (4) step(1, 32'h0004_2101, 0, a);
    step(1, 32'h0004_2101, 1, a);
    repeat (4) step(0, 0, 0, a);
    check("flush.busy", 32'(busy), 0);

    // Reset during an execute cycle
    do_reset();
    step(1, 32'h0000_003F, 0, a);
    step(1, 32'h0004_1881, 0, a);
    budget = 0;
    while (!m_exv && budget < 10) begin step(0, 0, 0, a); budget++; end
    check("midrst.ex_reached", 32'(m_exv), 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1;

    // Counter saturation
    do_reset();
    repeat (CMAX + 6) step(1, 32'h0000_003F, 0, a);
    step(0, 0, 0, a);
    check("sat.illegal_cnt", 32'(illegal_cnt), CMAX);
    do_reset();
    repeat (2 * CMAX + 12) step(1, mk(1, 1, 1, 1), 0, a);
    repeat (DEPTH * 2 + 4) step(0, 0, 0, a);
    check("sat.stall_cnt", 32'(stall_cnt), CMAX);

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0,
           mk($urandom_range(0, 13), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3)) | ($urandom() & 32'hFFE0_0000),
           $urandom_range(0, 39) == 0, a);
    end
    repeat (10) step(0, 0, 0, a);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
